// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the configurable UART receive path.
// Contents: parity encodings, FSM state encoding, oversampling constants,
// default divisor width and the 2-of-3 majority helper.
package uart_rx_frame_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DIV_WIDTH  = 16;

    localparam logic [1:0] UART_PAR_NONE = 2'd0;
    localparam logic [1:0] UART_PAR_ODD  = 2'd1;
    localparam logic [1:0] UART_PAR_EVEN = 2'd2;

    // Phases (within a 16-tick bit slot) at which rx is sampled; the bit is
    // decided on the last one.
    localparam logic [3:0] UART_PH_SAMP0  = 4'd7;
    localparam logic [3:0] UART_PH_SAMP1  = 4'd8;
    localparam logic [3:0] UART_PH_DECIDE = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_baud_gen.sv
// Oversample tick generator: down-counter with terminal-count compare.
// Ports:
//   clk, rstn   : clock, async active-low reset
//   i_restart   : synchronous restart; reloads from i_div so the next tick
//                 lands i_div+1 clocks later
//   i_div       : tick period minus 1
//   o_tick      : one-clock pulse every i_div+1 clocks
module uart_rx_frame_baud_gen
    import uart_rx_frame_pkg::*;
#(
    parameter int DIV_WIDTH = UART_DIV_WIDTH
)(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_tc;

    assign w_tc   = (r_cnt == '0);
    assign o_tick = w_tc & ~i_restart;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_restart || w_tc) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Runtime-configurable UART receiver: 5..8 data bits, optional parity,
// 1 or 2 stop bits, runtime baud divisor, 16x oversampling with 2-of-3
// majority vote, per-character error flags and a valid/ready output.
//
// Build option: define UART_PARITY_EN to honour the parity input and build
// the PARITY state and parity-error logic. Without it, parity is ignored,
// dout_perr stays 0 and a parity bit on the line is taken as a stop bit.
//
// Ports:
//   clk, rstn                  : clock, async active-low reset
//   rx                         : serial input (asynchronous, idles high)
//   div                        : oversample tick period minus 1
//   data_len                   : data bits minus 5
//   parity                     : 0 none, 1 odd, 2 even, 3 none
//   stop2                      : 1 selects two stop bits
//   dout, dout_perr, dout_ferr : received character and its error flags
//   dout_valid, dout_ready     : output handshake
//   overrun, overrun_clr       : sticky lost-character flag and its clear
//   busy                       : frame in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a high->low edge on the synchronised line
// ST_START  | validating the start bit (majority 1 = false start)
// ST_DATA   | shifting data bits in, LSB first
// ST_PARITY | checking the parity bit (UART_PARITY_EN builds only)
// ST_STOP1  | first stop bit; low sets the framing error
// ST_STOP2  | optional second stop bit; low also sets the framing error
// ST_DONE   | one cycle: hand the character to the output register
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DIV_WIDTH  = UART_DIV_WIDTH,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
)(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [1:0]           data_len,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    output logic [7:0]           dout,
    output logic                 dout_perr,
    output logic                 dout_ferr,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 busy
);

    logic                 r_rx_m;
    logic                 r_rx_s;
    logic                 r_rx_s_d;

    rx_state_t            r_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic [1:0]           r_dlen;
    logic                 r_stop2;
`ifdef UART_PARITY_EN
    logic [1:0]           r_par;
`endif
    logic [3:0]           r_ph;
    logic [2:0]           r_bi;
    logic                 r_s0;
    logic                 r_s1;
    logic [7:0]           r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic [7:0]           r_dout;
    logic                 r_dout_perr;
    logic                 r_dout_ferr;
    logic                 r_dout_valid;
    logic                 r_overrun;
    logic                 r_busy;

    logic                 w_start;
    logic                 w_tick;
    logic [3:0]           w_ph_now;
    logic                 w_decide;
    logic                 w_maj;
    logic                 w_par_en;
    logic                 w_last_data;
    logic                 w_deliver;
    logic                 w_overrun_set;
    logic [DIV_WIDTH-1:0] w_baud_div;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_m   <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_rx_m   <= rx;
            r_rx_s   <= r_rx_m;
            r_rx_s_d <= r_rx_s;
        end
    end

    // Only a real high->low transition starts a frame, so a held-low line
    // (break) produces a single frame and then waits for the line to rise.
    assign w_start = (r_state == ST_IDLE) && !r_rx_s && r_rx_s_d;

    // On the start cycle the divisor is not latched yet; load the live value.
    assign w_baud_div = w_start ? div : r_div;

    uart_rx_frame_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk       (clk),
        .rstn      (rstn),
        .i_restart (w_start),
        .i_div     (w_baud_div),
        .o_tick    (w_tick)
    );

    // The start-detect cycle counts as phase 0; each tick advances one phase.
    assign w_ph_now    = (r_ph == 4'(OVERSAMPLE - 1)) ? 4'd0 : r_ph + 4'd1;
    assign w_decide    = w_tick && (w_ph_now == UART_PH_DECIDE);
    assign w_maj       = maj3(r_s0, r_s1, r_rx_s);
    assign w_last_data = (r_bi == (3'(r_dlen) + 3'd4));

`ifdef UART_PARITY_EN
    assign w_par_en = (r_par == UART_PAR_ODD) || (r_par == UART_PAR_EVEN);
`else
    // Parity compiled out: the port is kept for drop-in compatibility only.
    assign w_par_en = 1'b0 & (|parity);
`endif

    assign w_deliver     = (r_state == ST_DONE) && (!r_dout_valid || dout_ready);
    assign w_overrun_set = (r_state == ST_DONE) && r_dout_valid && !dout_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_dlen       <= '0;
            r_stop2      <= 1'b0;
`ifdef UART_PARITY_EN
            r_par        <= UART_PAR_NONE;
`endif
            r_ph         <= '0;
            r_bi         <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_dout       <= '0;
            r_dout_perr  <= 1'b0;
            r_dout_ferr  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_tick) begin
                r_ph <= w_ph_now;
                if (w_ph_now == UART_PH_SAMP0) r_s0 <= r_rx_s;
                if (w_ph_now == UART_PH_SAMP1) r_s1 <= r_rx_s;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                        r_ph    <= '0;
                        r_bi    <= '0;
                        r_shift <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                        r_div   <= div;
                        r_dlen  <= data_len;
                        r_stop2 <= stop2;
`ifdef UART_PARITY_EN
                        r_par   <= parity;
`endif
                    end
                end
                ST_START: begin
                    if (w_decide) begin
                        if (w_maj) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift[r_bi] <= w_maj;
                        if (w_last_data) begin
                            r_state <= w_par_en ? ST_PARITY : ST_STOP1;
                        end else begin
                            r_bi <= r_bi + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (w_decide) begin
                        // Odd parity: data XOR parity bit must be 1; even: 0.
                        r_perr  <= ((^r_shift) ^ w_maj) != (r_par == UART_PAR_ODD);
                        r_state <= ST_STOP1;
                    end
                end
`endif
                ST_STOP1: begin
                    if (w_decide) begin
                        r_ferr  <= ~w_maj;
                        r_state <= r_stop2 ? ST_STOP2 : ST_DONE;
                    end
                end
                ST_STOP2: begin
                    if (w_decide) begin
                        r_ferr  <= r_ferr | ~w_maj;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A DONE load wins over a same-cycle handshake clear.
            if (w_deliver) begin
                r_dout       <= r_shift;
                r_dout_perr  <= r_perr;
                r_dout_ferr  <= r_ferr;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_perr  = r_dout_perr;
    assign dout_ferr  = r_dout_ferr;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are bit-banged on rx, expected
// characters go into a queue and are checked when the DUT hands them over.
module tb_uart_rx_frame;

    logic        clk;
    logic        rstn;
    logic        rx;
    logic [15:0] div;
    logic [1:0]  data_len;
    logic [1:0]  parity;
    logic        stop2;
    logic [7:0]  dout;
    logic        dout_perr;
    logic        dout_ferr;
    logic        dout_valid;
    logic        dout_ready;
    logic        overrun;
    logic        overrun_clr;
    logic        busy;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    uart_rx_frame dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .div         (div),
        .data_len    (data_len),
        .parity      (parity),
        .stop2       (stop2),
        .dout        (dout),
        .dout_perr   (dout_perr),
        .dout_ferr   (dout_ferr),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d;
        e.p = p;
        e.f = f;
        return e;
    endfunction

    // Handshake completes on the next rising edge; compare against the queue.
    always @(negedge clk) begin
        if (rstn && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_char observed=0x%0h expected=none", dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_dout", 32'(dout), 32'(e.d));
                chk("sb_perr", 32'(dout_perr), 32'(e.p));
                chk("sb_ferr", 32'(dout_ferr), 32'(e.f));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Precondition: called right after a rising edge.
    task automatic drive_bit(input logic b, input int bt);
        #1 rx = b;
        repeat (bt) @(posedge clk);
    endtask

    // pbit < 0 means no parity bit; stop1_val lets the first stop bit be forced low.
    task automatic send_frame(input logic [7:0] data, input int nbits, input int pbit,
                              input int nstop, input logic stop1_val, input int dv);
        int bt;
        bt = 16 * (dv + 1);
        @(posedge clk);
        drive_bit(1'b0, bt);
        for (int i = 0; i < nbits; i++) drive_bit(data[i], bt);
        if (pbit >= 0) drive_bit(pbit[0], bt);
        drive_bit(stop1_val, bt);
        for (int i = 1; i < nstop; i++) drive_bit(1'b1, bt);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int n;
        rstn        = 1'b0;
        rx          = 1'b1;
        div         = 16'd0;
        data_len    = 2'd3;
        parity      = 2'd0;
        stop2       = 1'b0;
        dout_ready  = 1'b1;
        overrun_clr = 1'b0;

        #23;
        chk("rst_dout",    32'(dout), 32'h0);
        chk("rst_perr",    32'(dout_perr), 32'h0);
        chk("rst_ferr",    32'(dout_ferr), 32'h0);
        chk("rst_valid",   32'(dout_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_busy",    32'(busy), 32'h0);
        #4 rstn = 1'b1;
        repeat (5) @(posedge clk);

        // 8N1 0xA5 with timing: rx falls 1ns after edge E0, rx_s low from
        // edge E0+2 (cycle 0), dout_valid set by edge E0+2+155.
        exp_q.push_back(mk(8'hA5, 1'b0, 1'b0));
        fork
            send_frame(8'hA5, 8, -1, 1, 1'b1, 0);
            begin
                @(posedge clk);
                n = 0;
                #1;
                while (!dout_valid && n < 400) begin
                    @(posedge clk);
                    n++;
                    #1;
                end
                chk("valid_rise_edge", 32'(n), 32'd157);
                @(posedge clk);
                #1;
                chk("valid_one_cycle", 32'(dout_valid), 32'h0);
            end
        join

        exp_q.push_back(mk(8'h00, 1'b0, 1'b0));
        send_frame(8'h00, 8, -1, 1, 1'b1, 0);
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0));
        send_frame(8'hFF, 8, -1, 1, 1'b1, 0);

        // Config changes mid-frame apply only to the next frame.
        exp_q.push_back(mk(8'h96, 1'b0, 1'b0));
        fork
            send_frame(8'h96, 8, -1, 1, 1'b1, 0);
            begin
                repeat (40) @(posedge clk);
                #1;
                data_len = 2'd0;
                div      = 16'd2;
                stop2    = 1'b1;
            end
        join
        data_len = 2'd1;
        div      = 16'd0;
        stop2    = 1'b0;
        exp_q.push_back(mk(8'h2A, 1'b0, 1'b0));
        send_frame(8'hEA, 6, -1, 1, 1'b1, 0);

        // 7E2, div=3, wrong parity bit (0x41 has two ones, even parity bit = 0).
        div      = 16'd3;
        data_len = 2'd2;
        parity   = 2'd2;
        stop2    = 1'b1;
`ifdef UART_PARITY_EN
        exp_q.push_back(mk(8'h41, 1'b1, 1'b0));
`else
        exp_q.push_back(mk(8'h41, 1'b0, 1'b0));
`endif
        send_frame(8'h41, 7, 1, 2, 1'b1, 3);
        chk("q_after_7e2", 32'(exp_q.size()), 32'd0);

        // 5N1 framing error, then a clean frame.
        div      = 16'd0;
        data_len = 2'd0;
        parity   = 2'd0;
        stop2    = 1'b0;
        exp_q.push_back(mk(8'h15, 1'b0, 1'b1));
        send_frame(8'h15, 5, -1, 1, 1'b0, 0);
        exp_q.push_back(mk(8'h1F, 1'b0, 1'b0));
        send_frame(8'h1F, 5, -1, 1, 1'b1, 0);
        chk("q_after_5n1", 32'(exp_q.size()), 32'd0);

        // 3-clock glitch: false start, busy cycles 1..9 only.
        data_len = 2'd3;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_c9", 32'(busy), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_c10", 32'(busy), 32'h0);
        repeat (40) @(posedge clk);
        chk("glitch_no_valid", 32'(dout_valid), 32'h0);

        // Overrun.
        dout_ready = 1'b0;
        send_frame(8'h11, 8, -1, 1, 1'b1, 0);
        chk("ovr_first_dout", 32'(dout), 32'h11);
        chk("ovr_first_valid", 32'(dout_valid), 32'h1);
        chk("ovr_first_flag", 32'(overrun), 32'h0);
        send_frame(8'h22, 8, -1, 1, 1'b1, 0);
        chk("ovr_hold_dout", 32'(dout), 32'h11);
        chk("ovr_flag_set", 32'(overrun), 32'h1);
        @(posedge clk);
        #1 overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        chk("ovr_flag_clr", 32'(overrun), 32'h0);
        exp_q.push_back(mk(8'h11, 1'b0, 1'b0));
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_valid_drop", 32'(dout_valid), 32'h0);

        // Reset in the middle of the data bits.
        dout_ready = 1'b0;
        send_frame(8'h5A, 8, -1, 1, 1'b1, 0);
        chk("pre_rst_dout", 32'(dout), 32'h5A);
        @(posedge clk);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b0, 16);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_dout",    32'(dout), 32'h0);
        chk("mid_rst_valid",   32'(dout_valid), 32'h0);
        chk("mid_rst_busy",    32'(busy), 32'h0);
        chk("mid_rst_ferr",    32'(dout_ferr), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b1;
        dout_ready = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        send_frame(8'h3C, 8, -1, 1, 1'b1, 0);

        repeat (10) @(posedge clk);
        chk("q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
